// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: received LFSR stream with its period marker word
interface lfsr_checker_if;
  logic       i_valid;
  logic [7:0] i_lfsr;
  logic [7:0] i_seed;
  modport master (output i_valid, i_lfsr, i_seed);
  modport slave (input i_valid, i_lfsr, i_seed);
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising PRBS-8 checker with error counter and marker period measurement
module lfsr_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  lfsr_checker_if.slave    s,
  output logic             o_lock,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_count,
  output logic [ERR_W-1:0] o_period,
  output logic             o_period_valid
);
  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;
  state_t           state;
  logic [7:0]       expected;
  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;
  logic [ERR_W-1:0] period_cnt;
  logic             armed;
  logic             hit;
  function automatic logic [7:0] nxt(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction
  assign hit = s.i_lfsr == expected;
  always_ff @(posedge clk) begin
    if (i_rst || i_soft_reset) begin
      state          <= UNLOCKED;
      expected       <= '0;
      match_cnt      <= '0;
      miss_cnt       <= '0;
      period_cnt     <= '0;
      armed          <= 1'b0;
      o_lock         <= 1'b0;
      o_err          <= 1'b0;
      o_err_count    <= '0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
    end else begin
      o_err          <= 1'b0;
      o_period_valid <= 1'b0;
      if (s.i_valid) begin
        case (state)
          UNLOCKED: if (s.i_lfsr != 8'h00) begin
            expected  <= nxt(s.i_lfsr);
            match_cnt <= '0;
            state     <= LOCKING;
          end
          LOCKING: if (hit) begin
            expected  <= nxt(expected);
            match_cnt <= match_cnt + 4'd1;
            if (match_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
              state      <= LOCKED;
              o_lock     <= 1'b1;
              miss_cnt   <= '0;
              period_cnt <= '0;
              armed      <= 1'b0;
            end
          end else if (s.i_lfsr != 8'h00) begin
            expected  <= nxt(s.i_lfsr);
            match_cnt <= '0;
          end else state <= UNLOCKED;
          default: begin
            // flywheel: prediction never follows the received word once locked
            expected   <= nxt(expected);
            period_cnt <= (&period_cnt) ? period_cnt : period_cnt + ERR_W'(1);
            if (hit) begin
              miss_cnt <= '0;
              if (s.i_lfsr == s.i_seed) begin
                if (armed) begin
                  o_period       <= period_cnt;
                  o_period_valid <= 1'b1;
                end
                period_cnt <= ERR_W'(1);
                armed      <= 1'b1;
              end
            end else begin
              o_err       <= 1'b1;
              o_err_count <= (&o_err_count) ? o_err_count : o_err_count + ERR_W'(1);
              miss_cnt    <= miss_cnt + 4'd1;
              if (miss_cnt + 4'd1 == 4'(UNLOCK_COUNT)) begin
                state  <= UNLOCKED;
                o_lock <= 1'b0;
                armed  <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end
endmodule
